m_ext_iter: RTL

- Parametrised iterative RV M-extension unit, the next generation of the current fixed-width multiply/divide wrapper.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU at a configurable XLEN.
- Multiplier retires a configurable number of bits per cycle.
- Adds valid/ready handshaking, pipeline flush, and RISC-V-exact divide-by-zero and signed-overflow results with single-cycle early-out.
- Sits beside the ALU in EX and stalls the pipeline until it responds.

---
 rtl/m_ext_iter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/m_ext_iter.sv
// Iterative RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU via shift-add
// (MUL_STEP multiplier bits per cycle), DIV/DIVU/REM/REMU via restoring
// division (one quotient bit per cycle). Operands are reduced to magnitudes
// on acceptance and the result sign is applied once the iteration is done.
// Divide-by-zero and signed overflow are resolved on acceptance (early-out).
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// MUL   | shift-add iterations on the 2*XLEN product
// DIV   | restoring division iterations
// DONE  | result presented, held until resp_valid && resp_ready

module m_ext_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int MUL_N = XLEN / MUL_STEP;
    localparam int CW    = $clog2(XLEN + 1);

    localparam logic [XLEN:0]     ONE1    = {{XLEN{1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   ONEX    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE2    = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic [2:0]          op;
    logic                neg_res;
    logic                early;
    logic [XLEN-1:0]     early_data;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [2*XLEN-1:0]   prod;
    logic [CW-1:0]       cnt;

    // Magnitude is formed in XLEN+1 bits so the most-negative value is exact;
    // the top bit is always zero afterwards and is dropped by the cast.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN:0] wide;
        wide = sgn ? (~{v[XLEN-1], v} + ONE1) : {1'b0, v};
        return XLEN'(wide);
    endfunction

    logic            sgn_a_in;
    logic            sgn_b_in;
    logic            b_zero;
    logic            ovf;
    logic            early_hit;
    logic [XLEN-1:0] early_val;
    logic            neg_in;
    logic            accept;

    // Request decode: operand signedness, result sign and early-out detection.
    always_comb begin
        sgn_a_in  = a[XLEN-1] & (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
        sgn_b_in  = b[XLEN-1] & (funct3 inside {3'd0, 3'd1, 3'd4, 3'd6});
        b_zero    = (b == '0);
        ovf       = (a == MIN_NEG) && (&b) && (funct3 inside {3'd4, 3'd6});
        early_hit = funct3[2] && (b_zero || ovf);
        early_val = '0;
        if (b_zero) begin
            early_val = funct3[1] ? a : '1;
        end else if (ovf) begin
            early_val = funct3[1] ? '0 : a;
        end
        // Remainders follow the dividend; products and quotients the XOR.
        neg_in = (funct3[2] && funct3[1]) ? sgn_a_in : (sgn_a_in ^ sgn_b_in);
        accept = req_valid && (state == IDLE) && !flush;
    end

    logic [XLEN+MUL_STEP-1:0] mul_sum;
    logic [XLEN:0]            div_sh;
    logic [XLEN:0]            div_dif;
    logic                     div_fit;
    logic [XLEN-1:0]          div_rem;

    // One iteration step of each datapath.
    always_comb begin
        mul_sum = {{MUL_STEP{1'b0}}, prod[2*XLEN-1:XLEN]}
                + ({{MUL_STEP{1'b0}}, mag_a} * {{XLEN{1'b0}}, prod[MUL_STEP-1:0]});
        div_sh  = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
        div_dif = div_sh - {1'b0, mag_b};
        div_fit = (div_sh >= {1'b0, mag_b});
        div_rem = XLEN'(div_fit ? div_dif : div_sh);
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result;

    // Final sign correction and result selection.
    always_comb begin
        prod_fix = neg_res ? (~prod + ONE2) : prod;
        quo_fix  = neg_res ? (~prod[XLEN-1:0] + ONEX) : prod[XLEN-1:0];
        rem_fix  = neg_res ? (~prod[2*XLEN-1:XLEN] + ONEX) : prod[2*XLEN-1:XLEN];
        if (early) begin
            result = early_data;
        end else begin
            case (op)
                3'd0:                result = prod_fix[XLEN-1:0];
                3'd1, 3'd2, 3'd3:    result = prod_fix[2*XLEN-1:XLEN];
                3'd4, 3'd5:          result = quo_fix;
                default:             result = rem_fix;
            endcase
        end
    end

    // Sequencer and datapath registers; flush overrides everything but reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op         <= '0;
            neg_res    <= 1'b0;
            early      <= 1'b0;
            early_data <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            prod       <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else if (flush) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op         <= funct3;
                        neg_res    <= neg_in;
                        early      <= early_hit;
                        early_data <= early_val;
                        mag_a      <= magnitude(a, sgn_a_in);
                        mag_b      <= magnitude(b, sgn_b_in);
                        if (early_hit) begin
                            state <= DONE;
                        end else if (funct3[2]) begin
                            prod  <= {{XLEN{1'b0}}, magnitude(a, sgn_a_in)};
                            cnt   <= CW'(XLEN - 1);
                            state <= DIV;
                        end else begin
                            prod  <= {{XLEN{1'b0}}, magnitude(b, sgn_b_in)};
                            cnt   <= CW'(MUL_N - 1);
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    prod <= {mul_sum, prod[XLEN-1:MUL_STEP]};
                    cnt  <= cnt - CNT_ONE;
                    if (cnt == '0) begin
                        state <= DONE;
                    end
                end
                DIV: begin
                    prod <= {div_rem, prod[XLEN-2:0], div_fit};
                    cnt  <= cnt - CNT_ONE;
                    if (cnt == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_data  <= result;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule
